// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the raw pins, deframes 11-bit frames and folds E0/F0 prefixes.
// Optional inactivity abort is compiled in with `define PS2_TIMEOUT_EN.
module ps2_keyboard_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] KEY_CODE,
    output logic       KEY_EXT,
    output logic       KEY_BREAK,
    output logic       KEY_VALID,
    output logic       PARITY_ERR,
    output logic       FRAME_ERR,
    output logic       BUSY
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // Preset to 1 so reset release on an idle-high line never looks like a falling edge.
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic                   fall, din;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], PS2_DATA};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign din  = data_sync_q[SYNC_STAGES-1];

    logic [1:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       ext_q, ext_d, brk_q, brk_d;
    logic [7:0] code_q, code_d;
    logic       kext_q, kext_d, kbrk_q, kbrk_d;
    logic       valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
    logic       expire;

`ifdef PS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    assign expire = (state_q != S_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES));
    assign tmo_d  = (state_q == S_IDLE || fall) ? '0 : tmo_q + 1'b1;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) tmo_q <= '0;
        else             tmo_q <= tmo_d;
    end
`else
    localparam int TMO_UNUSED = TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        code_d    = code_q;
        kext_d    = kext_q;
        kbrk_d    = kbrk_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        // Expiry takes precedence over a fall landing in the same cycle.
        if (expire) begin
            state_d = S_IDLE;
            ferr_d  = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
        end else if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!din) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = din;
                    state_d = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (!din) begin
                        ferr_d = 1'b1;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end else if (^{shift_q, par_q} == 1'b0) begin
                        perr_d = 1'b1;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end else if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        code_d  = shift_q;
                        kext_d  = ext_q;
                        kbrk_d  = brk_q;
                        ext_d   = 1'b0;
                        brk_d   = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            code_q    <= 8'd0;
            kext_q    <= 1'b0;
            kbrk_q    <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            code_q    <= code_d;
            kext_q    <= kext_d;
            kbrk_q    <= kbrk_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign KEY_CODE   = code_q;
    assign KEY_EXT    = kext_q;
    assign KEY_BREAK  = kbrk_q;
    assign KEY_VALID  = valid_q;
    assign PARITY_ERR = perr_q;
    assign FRAME_ERR  = ferr_q;
    assign BUSY       = (state_q != S_IDLE);

endmodule
